// File: rtl/conv_pkg.sv
// Shared types and helpers for the column-streaming convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_K,
    ST_FETCH,
    ST_COMPUTE,
    ST_EMIT,
    ST_DONE
  } conv_state_t;

  // Memory words needed to cover one image column.
  function automatic int unsigned calc_beats(input int unsigned img, input int unsigned lanes);
    return (img + lanes - 1) / lanes;
  endfunction

  // Output pixels per column of a valid KxK convolution.
  function automatic int unsigned calc_out_rows(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

  // Fixed-point rescale, saturation to data_w signed range, optional ReLU.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] acc,
                                                  input int unsigned      frac_bits,
                                                  input int unsigned      data_w,
                                                  input logic             relu);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    sh = acc >>> frac_bits;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi) res = hi;
    else if (sh < lo) res = lo;
    else res = sh;
    if (relu && (res < 64'sd0)) res = '0;
    return res;
  endfunction

endpackage

// File: rtl/conv_col_lane.sv
// One output row: accumulates a K-tap column dot product per cycle.
module conv_col_lane #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned K      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [K*DATA_W-1:0]     px,
  input  logic [K*DATA_W-1:0]     wt,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] col_sum;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
    return ACC_W'(p);
  endfunction

  // Sum of the K full-precision products for the current kernel column.
  always_comb begin
    col_sum = '0;
    for (int unsigned i = 0; i < K; i++) begin
      col_sum = col_sum + mac_term(px[i*DATA_W +: DATA_W], wt[i*DATA_W +: DATA_W]);
    end
  end

  // Accumulator: first compute cycle loads instead of adding.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? col_sum : acc + col_sum;
    end
  end

endmodule

// File: rtl/conv_col_stream_engine.sv
// Column-streaming KxK valid convolution with runtime kernel and output backpressure.
module conv_col_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned IMG_SIZE  = 28,
  parameter int unsigned K         = 5,
  parameter int unsigned BUS_LANES = 16,
  parameter int unsigned ADDR_W    = 12,
  localparam int unsigned OUT_ROWS = calc_out_rows(IMG_SIZE, K),
  localparam int unsigned BEATS    = calc_beats(IMG_SIZE, BUS_LANES),
  localparam int unsigned COL_W    = $clog2(IMG_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          relu_en,
  input  logic                          k_valid,
  input  logic [DATA_W-1:0]             k_data,
  output logic                          k_ready,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [BUS_LANES*DATA_W-1:0]   rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_ROWS*DATA_W-1:0]    out_data,
  output logic [COL_W-1:0]              out_col,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned SLOT_W = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned LCOL_W = $clog2(IMG_SIZE + 1);

  conv_state_t state, state_nx;

  logic [DATA_W-1:0]        kw [K][K];
  logic [SLOT_W-1:0]        k_row, k_col;
  logic [BEAT_W-1:0]        beat, rd_beat_q;
  logic                     rd_pend;
  logic [LCOL_W-1:0]        load_col;
  logic [SLOT_W-1:0]        wr_slot, wr_slot_inc;
  logic [SLOT_W-1:0]        cmp_slot, cmp_slot_inc, cmp_c;
  logic                     relu_q;
  logic                     k_last, fetch_last, cmp_last, job_last;
  logic                     lane_clr, lane_en;
  logic [IMG_SIZE*DATA_W-1:0] sel_vec;
  logic [K*DATA_W-1:0]      wt_col;

  always_comb begin
    k_last       = (k_row == SLOT_W'(K - 1)) && (k_col == SLOT_W'(K - 1));
    fetch_last   = (beat == BEAT_W'(BEATS));
    cmp_last     = (cmp_c == SLOT_W'(K - 1));
    job_last     = (load_col == LCOL_W'(IMG_SIZE));
    wr_slot_inc  = (wr_slot == SLOT_W'(K - 1)) ? '0 : wr_slot + 1'b1;
    cmp_slot_inc = (cmp_slot == SLOT_W'(K - 1)) ? '0 : cmp_slot + 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx  = state;
    k_ready   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    lane_clr  = 1'b0;
    lane_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_LOAD_K;
      end
      ST_LOAD_K: begin
        k_ready = 1'b1;
        if (k_valid && k_last) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en = !fetch_last;
        if (!fetch_last) rd_addr = ADDR_W'(load_col) * ADDR_W'(BEATS) + ADDR_W'(beat);
        if (fetch_last) state_nx = (load_col >= LCOL_W'(K - 1)) ? ST_COMPUTE : ST_FETCH;
      end
      ST_COMPUTE: begin
        lane_en  = 1'b1;
        lane_clr = (cmp_c == '0);
        if (cmp_last) state_nx = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = job_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Job control: kernel load, fetch sequencing, compute column walk, output column count.
  // After a column lands, the next write slot is also the oldest window column,
  // so it doubles as the compute start slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      kw        <= '{default: '0};
      k_row     <= '0;
      k_col     <= '0;
      beat      <= '0;
      rd_beat_q <= '0;
      rd_pend   <= 1'b0;
      load_col  <= '0;
      wr_slot   <= '0;
      cmp_slot  <= '0;
      cmp_c     <= '0;
      relu_q    <= 1'b0;
      out_col   <= '0;
    end else begin
      rd_pend   <= rd_en;
      rd_beat_q <= beat;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            relu_q   <= relu_en;
            k_row    <= '0;
            k_col    <= '0;
            beat     <= '0;
            load_col <= '0;
            wr_slot  <= '0;
            out_col  <= '0;
          end
        end
        ST_LOAD_K: begin
          if (k_valid) begin
            kw[k_row][k_col] <= k_data;
            if (k_col == SLOT_W'(K - 1)) begin
              k_col <= '0;
              k_row <= k_row + 1'b1;
            end else begin
              k_col <= k_col + 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (fetch_last) begin
            beat     <= '0;
            load_col <= load_col + 1'b1;
            wr_slot  <= wr_slot_inc;
            cmp_slot <= wr_slot_inc;
            cmp_c    <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        ST_COMPUTE: begin
          cmp_c    <= cmp_c + 1'b1;
          cmp_slot <= cmp_slot_inc;
        end
        ST_EMIT: begin
          if (out_ready && !job_last) out_col <= out_col + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_wt
    assign wt_col[i*DATA_W +: DATA_W] = kw[i][cmp_c];
  end

  // Window ring storage: one K-entry column history per image row.
  for (genvar r = 0; r < IMG_SIZE; r++) begin : g_row
    localparam int unsigned RB = r / BUS_LANES;
    localparam int unsigned RL = r % BUS_LANES;
    logic [DATA_W-1:0] px [K];

    // Capture this row's lane when its beat returns from memory.
    always_ff @(posedge clk) begin
      if (rd_pend && (rd_beat_q == BEAT_W'(RB))) px[wr_slot] <= rd_data[RL*DATA_W +: DATA_W];
    end

    assign sel_vec[r*DATA_W +: DATA_W] = px[cmp_slot];
  end

  for (genvar r = 0; r < OUT_ROWS; r++) begin : g_lane
    logic signed [ACC_W-1:0] acc_r;

    conv_col_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .K      (K)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (lane_clr),
      .en  (lane_en),
      .px  (sel_vec[r*DATA_W +: K*DATA_W]),
      .wt  (wt_col),
      .acc (acc_r)
    );

    assign out_data[r*DATA_W +: DATA_W] = DATA_W'(sat_relu(64'(acc_r), FRAC_BITS, DATA_W, relu_q));
  end

endmodule

// File: tb/tb_conv_col_stream_engine.sv
// Scoreboard bench for conv_col_stream_engine at the default 28x28 / K=5 configuration.
module tb_conv_col_stream_engine;

  localparam int IMG   = 28;
  localparam int OROWS = 24;
  localparam int BEATS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         relu_en = 1'b0;
  logic         k_valid = 1'b0;
  logic [15:0]  k_data = '0;
  logic         k_ready;
  logic         rd_en;
  logic [11:0]  rd_addr;
  logic [255:0] rd_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [383:0] out_data;
  logic [4:0]   out_col;
  logic         busy;
  logic         done;

  conv_col_stream_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .relu_en   (relu_en),
    .k_valid   (k_valid),
    .k_data    (k_data),
    .k_ready   (k_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           col;
    logic [383:0] data;
  } exp_t;

  exp_t sb[$];
  int   kern[5][5];
  int   img_mode = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   rcvd = 0;
  int   last_hs_cyc = -10;
  int   last_hs_col = -1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [15:0] pix(input int mode, input int r, input int c);
    int v;
    case (mode)
      0:       v = r + c;
      1:       v = c;
      2:       v = 127;
      default: v = ((r * 7 + c * 3) % 50) - 20;
    endcase
    return 16'(v);
  endfunction

  function automatic logic [383:0] exp_col(input int col, input bit relu);
    logic [383:0] v;
    longint acc;
    v = '0;
    for (int r = 0; r < OROWS; r++) begin
      acc = 0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          acc += longint'(kern[i][j]) * longint'(pix(img_mode, r + i, col + j));
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      if (relu && acc < 0) acc = 0;
      v[r*16 +: 16] = 16'(acc);
    end
    return v;
  endfunction

  function automatic logic [255:0] mem_word(input logic [11:0] addr);
    logic [255:0] w;
    int col, beat, row;
    col  = int'(addr) / BEATS;
    beat = int'(addr) % BEATS;
    for (int j = 0; j < 16; j++) begin
      row = beat * 16 + j;
      if (row < IMG) w[j*16 +: 16] = pix(img_mode, row, col);
      else           w[j*16 +: 16] = 16'($urandom);
    end
    return w;
  endfunction

  // Feature-map memory: one-cycle read latency, junk on the bus otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem_word(rd_addr);
    else       rd_data <= {8{$urandom}};
  end

  // Output monitor: pops the scoreboard on every handshake, checks done placement.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 512'(1), 512'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_col", 512'(out_col), 512'(e.col));
          chk("out_data", 512'(out_data), 512'(e.data));
        end
        rcvd++;
        last_hs_cyc = cyc;
        last_hs_col = int'(out_col);
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", 512'(cyc), 512'(last_hs_cyc + 1));
        chk("done_last_col", 512'(last_hs_col), 512'(OROWS - 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_kern_all(input int v);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        kern[i][j] = v;
  endtask

  task automatic start_and_load(input bit relu, input bit gap, output int n);
    start   = 1'b1;
    relu_en = relu;
    tick();
    start   = 1'b0;
    relu_en = !relu;
    n = 0;
    chk("k_ready", 512'(k_ready), 512'(1));
    for (int w = 0; w < 25; w++) begin
      if (gap && w == 7) begin
        k_valid = 1'b0;
        k_data  = 16'h5a5a;
        tick();
        n++;
      end
      k_valid = 1'b1;
      k_data  = 16'(kern[w / 5][w % 5]);
      tick();
      n++;
    end
    k_valid = 1'b0;
  endtask

  task automatic run_job(input bit relu, input bit gap, input int stall_col, input bit poke);
    int n, lat;
    bit seen, got_done, stalled;
    for (int c = 0; c < OROWS; c++) sb.push_back('{c, exp_col(c, relu)});
    done_cnt = 0;
    rcvd     = 0;
    lat      = -1;
    seen     = 0;
    got_done = 0;
    stalled  = 0;
    start_and_load(relu, gap, n);
    for (int t = 0; t < 4000 && !got_done; t++) begin
      if (poke && n == 28) begin
        start   = 1'b1;
        k_valid = 1'b1;
        k_data  = 16'h7fff;
      end else if (poke && n == 29) begin
        start   = 1'b0;
        k_valid = 1'b0;
      end
      if (out_valid && !seen) begin
        seen = 1;
        lat  = n;
      end
      if (out_valid && !stalled && stall_col >= 0 && int'(out_col) == stall_col) begin
        stalled   = 1;
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick();
          n++;
          chk("stall_valid", 512'(out_valid), 512'(1));
          chk("stall_col", 512'(out_col), 512'(stall_col));
          chk("stall_data", 512'(out_data), 512'(sb[0].data));
          chk("stall_rd_en", 512'(rd_en), 512'(0));
        end
        out_ready = 1'b1;
      end
      if (done) got_done = 1;
      else begin
        tick();
        n++;
      end
    end
    chk("done_seen", 512'(got_done), 512'(1));
    for (int s = 0; s < 3; s++) tick();
    chk("done_count", 512'(done_cnt), 512'(1));
    chk("cols_rcvd", 512'(rcvd), 512'(OROWS));
    chk("sb_empty", 512'(sb.size()), 512'(0));
    chk("idle_busy", 512'(busy), 512'(0));
    if (!gap) chk("first_latency", 512'(lat), 512'(45));
    sb.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_out_valid"}, 512'(out_valid), 512'(0));
    chk({tag, "_done"}, 512'(done), 512'(0));
    chk({tag, "_k_ready"}, 512'(k_ready), 512'(0));
    chk({tag, "_rd_en"}, 512'(rd_en), 512'(0));
    chk({tag, "_rd_addr"}, 512'(rd_addr), 512'(0));
    chk({tag, "_out_data"}, 512'(out_data), 512'(0));
    chk({tag, "_out_col"}, 512'(out_col), 512'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Identity kernel, pixel = r+c, with a stray start pulse mid-job.
    img_mode = 0;
    set_kern_all(0);
    kern[2][2] = 1;
    run_job(1'b0, 1'b0, -1, 1'b1);

    // Edge-detector kernel on pixel = c: every output is 74.
    img_mode = 1;
    kern[0] = '{-2, -1, 0, 1, 2};
    kern[1] = '{-3, -2, 0, 2, 3};
    kern[2] = '{-4, -3, 0, 3, 4};
    kern[3] = '{-3, -2, 0, 2, 3};
    kern[4] = '{-2, -1, 0, 1, 2};
    run_job(1'b0, 1'b1, -1, 1'b0);

    // Positive saturation, then large negatives clamped by ReLU.
    img_mode = 2;
    set_kern_all(127);
    run_job(1'b0, 1'b0, -1, 1'b0);
    set_kern_all(-127);
    run_job(1'b1, 1'b0, -1, 1'b0);

    // Mixed-sign kernel and image with a 10-cycle stall at column 3.
    img_mode = 3;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        kern[i][j] = int'($urandom_range(0, 6)) - 3;
    run_job(1'b0, 1'b0, 3, 1'b0);

    // Reset mid-COMPUTE abandons the job; next job must reload its kernel.
    img_mode = 0;
    set_kern_all(1);
    start_and_load(1'b0, 1'b0, n);
    while (n < 41) begin
      tick();
      n++;
    end
    chk("pre_rst_busy", 512'(busy), 512'(1));
    rst = 1'b1;
    tick();
    check_idle_outputs("midjob_rst");
    rst = 1'b0;
    tick();
    set_kern_all(0);
    kern[2][2] = 1;
    run_job(1'b0, 1'b0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
